// File: rtl/exp_sp_arbiter.sv
// exp_sp_arbiter: round-robin sharing of one single-cycle exp/softplus cell among NUM_REQ requesters.
// Define EXP_SP_ARB_PERF_EN to build the 32-bit issue counter; otherwise perf_issue_cnt is tied to 0.
module exp_sp_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_mode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_y,
  output logic                          cell_valid_in,
  output logic [DATA_WIDTH-1:0]         cell_x,
  output logic                          cell_mode,
  input  logic                          cell_valid_out,
  input  logic [DATA_WIDTH-1:0]         cell_y,
  output logic                          halted,
  output logic                          err_spurious,
  output logic [31:0]                   perf_issue_cnt
);
  localparam int TW = $clog2(NUM_REQ);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]                    r_state;
  logic [TW-1:0]                 r_ptr;
  logic                          r_inflight;
  logic [TW-1:0]                 r_tag;
  logic [NUM_REQ-1:0]            r_rsp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] r_rsp_y;
  logic                          r_err;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic [TW-1:0]      w_gidx;
  logic               w_found;
  logic [1:0]         w_state_nxt;

  always_comb begin : p_gnt
    logic [TW:0] j;
    w_elig = req_valid & ~r_rsp_valid;
    if (r_inflight) w_elig[r_tag] = 1'b0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_gnt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = {1'b0, r_ptr} + (TW+1)'(k);
      j = (j >= (TW+1)'(NUM_REQ)) ? j - (TW+1)'(NUM_REQ) : j;
      if (!w_found && w_elig[j]) begin
        w_found = 1'b1;
        w_gidx  = j[TW-1:0];
      end
    end
    w_found = w_found && r_state == S_RUN && en;
    if (w_found) w_gnt[w_gidx] = 1'b1;
  end

  // DRAIN also exits once nothing is in flight, since a 1-cycle cell may return before DRAIN is entered
  always_comb
    w_state_nxt = (r_state == S_RUN && !en)                                ? (r_inflight ? S_DRAIN : S_HALT) :
                  (r_state == S_DRAIN && (cell_valid_out || !r_inflight))  ? S_HALT :
                  (r_state == S_HALT && en)                                ? S_RUN : r_state;

  assign req_ready     = w_gnt;
  assign cell_valid_in = w_found;
  assign cell_x        = w_found ? req_x[w_gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign cell_mode     = w_found & req_mode[w_gidx];
  assign rsp_valid     = r_rsp_valid;
  assign rsp_y         = r_rsp_y;
  assign halted        = r_state == S_HALT;
  assign err_spurious  = r_err;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_HALT;
      r_ptr       <= '0;
      r_inflight  <= 1'b0;
      r_tag       <= '0;
      r_rsp_valid <= '0;
      r_rsp_y     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_found) begin
        r_ptr      <= (w_gidx == TW'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
        r_inflight <= 1'b1;
        r_tag      <= w_gidx;
      end else if (cell_valid_out) begin
        r_inflight <= 1'b0;
      end
      if (cell_valid_out && !r_inflight) r_err <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_rsp_valid[i] && rsp_ready[i]) r_rsp_valid[i] <= 1'b0;
        if (cell_valid_out && r_inflight && r_tag == TW'(i)) begin
          r_rsp_valid[i]                         <= 1'b1;
          r_rsp_y[i*DATA_WIDTH +: DATA_WIDTH]    <= cell_y;
        end
      end
    end

`ifdef EXP_SP_ARB_PERF_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_perf <= '0;
    else if (w_found) r_perf <= r_perf + 32'd1;
  assign perf_issue_cnt = r_perf;
`else
  assign perf_issue_cnt = '0;
`endif
endmodule
